// File: rtl/sdith_online_pkg.sv
// Shared definitions for the SDitH online-phase scheduler: FSM encoding, widths and
// per-parameter-set constants.
`ifndef CLOG2
`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package sdith_online_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLaunch,
    StWaitPc,
    StDrain,
    StWaitH2,
    StFin
  } state_t;

  localparam int unsigned TAU_L1 = 17;
  localparam int unsigned TAU_L3 = 26;
  localparam int unsigned TAU_L5 = 34;
  localparam int unsigned T_L1 = 3;
  localparam int unsigned T_L3 = 3;
  localparam int unsigned T_L5 = 4;
  localparam int unsigned D_HYPERCUBE_DEF = 8;

  // Broadcast share is {alpha, beta, v}, each T elements of 32 bits.
  function automatic int unsigned share_w(input int unsigned t);
    return 96 * t;
  endfunction

endpackage

// File: rtl/share_capture_buf.sv
// Per-lane share capture registers with a done mask and a drain-index read mux.
module share_capture_buf #(
  parameter int unsigned N_PC    = 2,
  parameter int unsigned SHARE_W = 288,
  parameter int unsigned IDX_W   = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic [N_PC-1:0]         i_cap_en,
  input  logic [N_PC*SHARE_W-1:0] i_share,
  input  logic [IDX_W-1:0]        i_rd_idx,
  output logic [N_PC-1:0]         o_mask,
  output logic [SHARE_W-1:0]      o_share
);

  logic [SHARE_W-1:0] buf_q [N_PC];
  logic [N_PC-1:0]    mask_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mask_q <= '0;
    end else if (i_clr) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_q | i_cap_en;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_PC; i++) buf_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PC; i++) begin
        if (i_cap_en[i]) buf_q[i] <= i_share[i*SHARE_W +: SHARE_W];
      end
    end
  end

  always_comb begin
    o_mask  = mask_q;
    o_share = '0;
    for (int i = 0; i < N_PC; i++) begin
      if (i_rd_idx == IDX_W'(i)) o_share = buf_q[i];
    end
  end

endmodule

// File: rtl/online_party_sched.sv
// Online-phase scheduler: walks tau x party batches over N_PC lanes and streams the
// captured broadcast shares in canonical order into hash_2.
module online_party_sched
  import sdith_online_pkg::*;
#(
  parameter int unsigned TAU         = 17,
  parameter int unsigned D_HYPERCUBE = 8,
  parameter int unsigned T           = 3,
  parameter int unsigned N_PC        = 2,
  parameter int unsigned SHARE_W     = share_w(T)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_start,
  input  logic                                i_abort,
  output logic                                o_busy,
  output logic                                o_done,
  output logic [`CLOG2(TAU)-1:0]              o_abrec_addr,
  output logic                                o_abrec_rd,
  output logic [N_PC-1:0]                     o_pc_start,
  output logic [`CLOG2(D_HYPERCUBE):0]        o_pc_d_base,
  input  logic [N_PC-1:0]                     i_pc_done,
  input  logic [N_PC*SHARE_W-1:0]             i_pc_share,
  output logic [SHARE_W-1:0]                  o_share,
  output logic                                o_share_valid,
  input  logic                                i_share_ready,
  input  logic                                i_h2_done
);

  localparam int unsigned TAU_W = `CLOG2(TAU);
  localparam int unsigned DB_W  = `CLOG2(D_HYPERCUBE) + 1;
  localparam int unsigned IDX_W = `CLOG2(N_PC);

  if ((D_HYPERCUBE % N_PC) != 0) begin : g_bad_npc
    $error("N_PC must divide D_HYPERCUBE");
  end

  state_t             state_q, state_d;
  logic [TAU_W-1:0]   tau_q;
  logic [DB_W-1:0]    d_base_q;
  logic [IDX_W-1:0]   idx_q;
  logic               h2_seen_q;
  logic [N_PC-1:0]    mask;
  logic [N_PC-1:0]    cap_en;
  logic [SHARE_W-1:0] buf_share;
  logic               start_go, accept, idx_last, batch_last, d_last, tau_last;
  logic               mask_full, buf_clr;

  always_comb begin
    start_go   = (state_q == StIdle) && i_start && !i_abort;
    // Only first done per lane per batch is captured; repeats are dropped.
    cap_en     = ((state_q == StWaitPc) && !i_abort) ? (i_pc_done & ~mask) : '0;
    mask_full  = &(mask | cap_en);
    accept     = (state_q == StDrain) && i_share_ready;
    idx_last   = (idx_q == IDX_W'(N_PC - 1));
    batch_last = accept && idx_last;
    d_last     = (d_base_q == DB_W'(D_HYPERCUBE - N_PC));
    tau_last   = (tau_q == TAU_W'(TAU - 1));
    buf_clr    = i_abort || start_go || batch_last;
  end

  share_capture_buf #(
    .N_PC    (N_PC),
    .SHARE_W (SHARE_W),
    .IDX_W   (IDX_W)
  ) u_buf (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (buf_clr),
    .i_cap_en (cap_en),
    .i_share  (i_pc_share),
    .i_rd_idx (idx_q),
    .o_mask   (mask),
    .o_share  (buf_share)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (i_start) state_d = StFetch;
        StFetch:  state_d = StLaunch;
        StLaunch: state_d = StWaitPc;
        StWaitPc: if (mask_full) state_d = StDrain;
        StDrain: begin
          if (batch_last) begin
            if (!d_last)       state_d = StLaunch;
            else if (tau_last) state_d = StWaitH2;
            else               state_d = StFetch;
          end
        end
        // The live pulse counts too, so o_done lands one cycle after a late i_h2_done.
        StWaitH2: if (h2_seen_q || i_h2_done) state_d = StFin;
        StFin:    state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      tau_q     <= '0;
      d_base_q  <= '0;
      idx_q     <= '0;
      h2_seen_q <= 1'b0;
    end else begin
      if (start_go) begin
        tau_q     <= '0;
        d_base_q  <= '0;
        idx_q     <= '0;
        h2_seen_q <= 1'b0;
      end else if ((state_q != StIdle) && i_h2_done) begin
        h2_seen_q <= 1'b1;
      end
      if (accept) begin
        if (idx_last) begin
          idx_q <= '0;
          if (d_last) begin
            d_base_q <= '0;
            tau_q    <= tau_last ? '0 : tau_q + TAU_W'(1);
          end else begin
            d_base_q <= d_base_q + DB_W'(N_PC);
          end
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    o_busy        = (state_q != StIdle);
    o_done        = (state_q == StFin);
    o_abrec_rd    = (state_q == StFetch);
    o_pc_start    = {N_PC{state_q == StLaunch}};
    o_share_valid = (state_q == StDrain);
    o_abrec_addr  = tau_q;
    o_pc_d_base   = d_base_q;
    o_share       = buf_share;
  end

endmodule

// File: doc/online_party_sched.md
# online_party_sched

Parametrised scheduler for the online phase of SDitH signing. It walks the TAU × D_HYPERCUBE party-computation loop and launches N_PC party-computation lanes in parallel per batch. It captures each lane's broadcast share and streams the shares in canonical order over a valid/ready port into hash_2, then waits for hash_2 to finish before pulsing done. It sits between the signing top level, the party-computation lanes and hash_2.

## Interface
Parameters:
- TAU, 17: repetitions; L3 = 26, L5 = 34.
- D_HYPERCUBE, 8: parties per repetition.
- T, 3: field elements per alpha/beta/v; L5 = 4.
- N_PC, 2: parallel lanes. Must divide D_HYPERCUBE; elaboration error otherwise.
- SHARE_W, 96*T: bits per broadcast share, {alpha, beta, v}.

Ports:
- Clock and reset: i_clk, i_rst. Reset is synchronous and active-high on clock i_clk.
- i_start, in, 1: start a run; sampled only in IDLE.
- i_abort, in, 1: cancel the run from any state.
- o_busy, out, 1: high in every state except IDLE.
- o_done, out, 1: one-cycle pulse when a run completes.
- o_abrec_addr, out, CLOG2(TAU): tau index for the a/b/r/eps/c operand memories.
- o_abrec_rd, out, 1: one-cycle read strobe for the operands.
- o_pc_start, out, N_PC: one-cycle start, one bit per lane.
- o_pc_d_base, out, CLOG2(D_HYPERCUBE)+1: lane l computes party d_base+l.
- i_pc_done, in, N_PC: per-lane done pulse.
- i_pc_share, in, N_PC*SHARE_W: lane shares; lane l occupies bits [l*SHARE_W +: SHARE_W]; sampled on that lane's done pulse.
- o_share, out, SHARE_W: share presented to hash_2.
- o_share_valid, out, 1: share valid.
- i_share_ready, in, 1: hash_2 ready.
- i_h2_done, in, 1: hash_2 done pulse.

## Operation
States: IDLE, FETCH, LAUNCH, WAIT_PC, DRAIN, WAIT_H2, FIN.
- IDLE: on i_start, clear tau = 0, d_base = 0, done mask, and the h2 sticky flag; go to FETCH.
- FETCH: drive o_abrec_rd = 1 and o_abrec_addr = tau for one cycle; go to LAUNCH.
- LAUNCH: drive o_pc_start = all ones for one cycle; go to WAIT_PC.
- WAIT_PC: on each i_pc_done[l], capture lane l's slice into buffer entry l and set mask[l].
  - Repeated or extra done pulses on a lane whose mask bit is already set are ignored; the buffer is not overwritten.
  - When the mask is all ones, go to DRAIN with drain index 0.
- DRAIN: present buffer[idx] with o_share_valid = 1.
  - On valid & ready, advance idx.
  - After entry N_PC-1 is accepted, clear the mask and set d_base += N_PC.
  - If d_base == D_HYPERCUBE: set d_base = 0 and tau += 1.
    - tau == TAU → WAIT_H2.
    - Otherwise → FETCH.
  - Otherwise → LAUNCH. Operands are unchanged within a tau.
- WAIT_H2: leave when the h2 sticky flag is set. The flag is set by any i_h2_done seen since start, so an early done is not lost. Go to FIN.
- FIN: o_done = 1 for one cycle; go to IDLE.
- Stream order: tau-major, then d ascending; exactly TAU*D_HYPERCUBE shares per run.
- i_abort: next state is IDLE from any state. No o_done, no further strobes; buffer contents discarded. If i_abort and i_start are both high in IDLE, abort wins.
- i_start outside IDLE is ignored.
- i_pc_done outside WAIT_PC is ignored.

## Timing
- Reset values:
  - State: IDLE.
  - o_busy = 0, o_done = 0, o_abrec_rd = 0, o_pc_start = 0, o_share_valid = 0.
  - o_abrec_addr = 0, o_pc_d_base = 0, o_share = 0.
  - Mask, tau, d_base and the sticky flag cleared.
- Pipeline from start:
  - Cycle 0: i_start sampled.
  - Cycle 1: FETCH (rd strobe).
  - Cycle 2: LAUNCH (o_pc_start).
  - Cycle 3 onward: WAIT_PC.
- WAIT_PC → DRAIN takes one cycle after the cycle in which the last done pulse is captured.
- o_share_valid is registered; o_share is stable while valid & !ready.
- With ready held high, DRAIN lasts exactly N_PC cycles.
- o_pc_d_base and o_abrec_addr are held constant from LAUNCH until the next DRAIN completes.
- o_done follows the cycle in which the sticky flag is observed in WAIT_H2.
- No combinational path from any input to any output.

## Structure
- Shared package sdith_online_pkg:
  - State encoding.
  - CLOG2 macro usage.
  - SHARE_W computation.
  - Per-parameter-set TAU, T and D_HYPERCUBE constants.
- One sub-module, share_capture_buf: N_PC × SHARE_W register file with a per-entry capture enable, a done mask, and a read mux indexed by the drain index.
- Counters (tau, d_base, idx) and the FSM live in online_party_sched.

## Test plan
- Basic order: TAU = 2, D = 8, N_PC = 2; lanes respond after 5 cycles with share = {tau, d}. Expect 16 shares in order (0,0)…(1,7), o_abrec_rd pulses at tau 0 and 1, and o_done one cycle after i_h2_done.
- Out-of-order lanes: lane 1 done 3 cycles before lane 0. Expect the stream still emits d_base+0 before d_base+1, and DRAIN is entered only after lane 0 is done.
- Backpressure: i_share_ready toggles 0/1 every cycle. Expect o_share stable while stalled, no shares lost or duplicated, 16 handshakes total.
- Abort: i_abort in DRAIN at tau = 1, idx = 1. Expect IDLE next cycle, o_busy = 0, no o_done; a new i_start restarts at tau 0, d_base 0.
- Early h2 done and ignored start: i_h2_done pulses during tau 1 WAIT_PC, and i_start pulses mid-run. Expect o_done in the cycle after WAIT_H2 is entered, and exactly one run executed.
- N_PC = 1, TAU = 17, D = 8: 136 shares, o_pc_start pulses 136 times, o_pc_d_base cycles 0…7 per tau.
